// File: rtl/alu_issue_stage_pkg.sv
// Shared types and encodings for the ALU issue stage: ALU op codes, MIPS-I opcode/funct
// constants, the decoded-issue record and the skid buffer states.
package alu_issue_stage_pkg;

  localparam int ALU_CTRL_WIDTH = 5;

  typedef enum logic [ALU_CTRL_WIDTH-1:0] {
    ALU_OP_ADD  = 5'd0,  ALU_OP_ADDU = 5'd1,  ALU_OP_SUB  = 5'd2,  ALU_OP_SUBU = 5'd3,
    ALU_OP_AND  = 5'd4,  ALU_OP_OR   = 5'd5,  ALU_OP_XOR  = 5'd6,  ALU_OP_NOR  = 5'd7,
    ALU_OP_SLT  = 5'd8,  ALU_OP_SLTU = 5'd9,  ALU_OP_SLL  = 5'd10, ALU_OP_SRL  = 5'd11,
    ALU_OP_SRA  = 5'd12, ALU_OP_LUI  = 5'd13, ALU_OP_EQ   = 5'd14, ALU_OP_NEQ  = 5'd15,
    ALU_OP_LEZ  = 5'd16, ALU_OP_GTZ  = 5'd17, ALU_OP_LTZ  = 5'd18, ALU_OP_GEZ  = 5'd19,
    ALU_OP_OP2  = 5'd20
  } alu_op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01;
  localparam logic [5:0] OPC_BEQ   = 6'h04, OPC_BNE   = 6'h05, OPC_BLEZ  = 6'h06, OPC_BGTZ = 6'h07;
  localparam logic [5:0] OPC_ADDI  = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI  = 6'h0A, OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C, OPC_ORI   = 6'h0D, OPC_XORI  = 6'h0E, OPC_LUI  = 6'h0F;
  localparam logic [5:0] OPC_LB    = 6'h20, OPC_LH    = 6'h21, OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_LBU   = 6'h24, OPC_LHU   = 6'h25;
  localparam logic [5:0] OPC_SB    = 6'h28, OPC_SH    = 6'h29, OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_e     ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        ovf_chk;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        illegal;
  } issue_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_st_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Valid/ready handshake bundle for the issue stage: regfile side in, EX side out.
interface alu_issue_stage_if
  import alu_issue_stage_pkg::*;
#(parameter int CTRL_W = ALU_CTRL_WIDTH);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       rs_data;
  logic [31:0]       rt_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [31:0]       out_op1;
  logic [31:0]       out_op2;
  logic              out_ovf_chk;
  logic              out_wr_en;
  logic [4:0]        out_wr_reg;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_op1, out_op2, out_ovf_chk,
           out_wr_en, out_wr_reg, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_op1, out_op2, out_ovf_chk,
           out_wr_en, out_wr_reg, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS-I decode into ALU ctrl/operands and writeback info.
module alu_issue_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output issue_t      dec
);
  logic [5:0]  opc, funct;
  logic [4:0]  rt_f, rd_f, sa;
  logic [15:0] imm;
  logic        ill;
  logic        unused_rs_f;

  assign opc   = instr[31:26];
  assign rt_f  = instr[20:16];
  assign rd_f  = instr[15:11];
  assign sa    = instr[10:6];
  assign funct = instr[5:0];
  assign imm   = instr[15:0];
  // rs field only matters to operand forwarding upstream
  assign unused_rs_f = ^instr[25:21];

  always_comb begin
    dec        = '0;
    dec.ctrl   = ALU_OP_OP2;
    dec.op1    = rs_val;
    dec.op2    = rt_val;
    dec.wr_reg = rt_f;
    ill        = 1'b0;
    case (opc)
      OPC_SPECIAL: begin
        dec.wr_reg = rd_f;
        dec.wr_en  = 1'b1;
        case (funct)
          FN_ADD:  begin dec.ctrl = ALU_OP_ADD; dec.ovf_chk = 1'b1; end
          FN_ADDU: dec.ctrl = ALU_OP_ADDU;
          FN_SUB:  begin dec.ctrl = ALU_OP_SUB; dec.ovf_chk = 1'b1; end
          FN_SUBU: dec.ctrl = ALU_OP_SUBU;
          FN_AND:  dec.ctrl = ALU_OP_AND;
          FN_OR:   dec.ctrl = ALU_OP_OR;
          FN_XOR:  dec.ctrl = ALU_OP_XOR;
          FN_NOR:  dec.ctrl = ALU_OP_NOR;
          FN_SLT:  dec.ctrl = ALU_OP_SLT;
          FN_SLTU: dec.ctrl = ALU_OP_SLTU;
          FN_SLL:  begin dec.ctrl = ALU_OP_SLL; dec.op1 = {27'd0, sa}; end
          FN_SRL:  begin dec.ctrl = ALU_OP_SRL; dec.op1 = {27'd0, sa}; end
          FN_SRA:  begin dec.ctrl = ALU_OP_SRA; dec.op1 = {27'd0, sa}; end
          FN_SLLV: dec.ctrl = ALU_OP_SLL;
          FN_SRLV: dec.ctrl = ALU_OP_SRL;
          FN_SRAV: dec.ctrl = ALU_OP_SRA;
          default: ill = 1'b1;
        endcase
      end
      OPC_REGIMM: begin
        if (rt_f == 5'd0)      dec.ctrl = ALU_OP_LTZ;
        else if (rt_f == 5'd1) dec.ctrl = ALU_OP_GEZ;
        else                   ill = 1'b1;
      end
      OPC_BEQ:  dec.ctrl = ALU_OP_EQ;
      OPC_BNE:  dec.ctrl = ALU_OP_NEQ;
      OPC_BLEZ: dec.ctrl = ALU_OP_LEZ;
      OPC_BGTZ: dec.ctrl = ALU_OP_GTZ;
      OPC_ADDI:  begin dec.ctrl = ALU_OP_ADD;  dec.op2 = sext16(imm); dec.wr_en = 1'b1; dec.ovf_chk = 1'b1; end
      OPC_ADDIU: begin dec.ctrl = ALU_OP_ADDU; dec.op2 = sext16(imm); dec.wr_en = 1'b1; end
      OPC_SLTI:  begin dec.ctrl = ALU_OP_SLT;  dec.op2 = sext16(imm); dec.wr_en = 1'b1; end
      OPC_SLTIU: begin dec.ctrl = ALU_OP_SLTU; dec.op2 = sext16(imm); dec.wr_en = 1'b1; end
      OPC_ANDI:  begin dec.ctrl = ALU_OP_AND;  dec.op2 = {16'd0, imm}; dec.wr_en = 1'b1; end
      OPC_ORI:   begin dec.ctrl = ALU_OP_OR;   dec.op2 = {16'd0, imm}; dec.wr_en = 1'b1; end
      OPC_XORI:  begin dec.ctrl = ALU_OP_XOR;  dec.op2 = {16'd0, imm}; dec.wr_en = 1'b1; end
      OPC_LUI:   begin dec.ctrl = ALU_OP_LUI;  dec.op2 = {16'd0, imm}; dec.wr_en = 1'b1; end
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: begin
        dec.ctrl = ALU_OP_ADDU; dec.op2 = sext16(imm); dec.wr_en = 1'b1;
      end
      OPC_SB, OPC_SH, OPC_SW: begin
        dec.ctrl = ALU_OP_ADDU; dec.op2 = sext16(imm);
      end
      default: ill = 1'b1;
    endcase

    if (ill) begin
      dec.ctrl    = ALU_OP_OP2;
      dec.wr_en   = 1'b0;
      dec.wr_reg  = 5'd0;
      dec.ovf_chk = 1'b0;
      dec.illegal = 1'b1;
    end
    // $zero is never a real destination
    if (dec.wr_reg == 5'd0) dec.wr_en = 1'b0;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, then a 2-entry skid buffer toward the ALU.
// Optional ALU_ISSUE_FWD_EN adds EX->ID operand forwarding ports.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(parameter int ALUCTRL_WIDTH = ALU_CTRL_WIDTH)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
`ifdef ALU_ISSUE_FWD_EN
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_reg,
  input  logic [31:0] ex_res,
`endif
  alu_issue_stage_if.slave bus
);
  skid_st_e    state, state_nxt;
  logic        in_rdy_q;
  logic        in_xfer, out_xfer, out_vld;
  logic        ld_main, ld_main_skid, ld_skid;
  logic [31:0] rs_val, rt_val;
  issue_t      dec, main_q, skid_q;

`ifdef ALU_ISSUE_FWD_EN
  logic [4:0] rs_f, rt_f;
  assign rs_f   = bus.in_instr[25:21];
  assign rt_f   = bus.in_instr[20:16];
  assign rs_val = (ex_wr_en && ex_wr_reg == rs_f && rs_f != 5'd0) ? ex_res : bus.rs_data;
  assign rt_val = (ex_wr_en && ex_wr_reg == rt_f && rt_f != 5'd0) ? ex_res : bus.rt_data;
`else
  assign rs_val = bus.rs_data;
  assign rt_val = bus.rt_data;
`endif

  alu_issue_decode u_dec (
    .instr  (bus.in_instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .dec    (dec)
  );

  assign out_vld  = (state != ST_EMPTY);
  assign in_xfer  = bus.in_valid & in_rdy_q;
  assign out_xfer = out_vld & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_rdy_q <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_rdy_q <= (state_nxt != ST_TWO);
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_main      = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) begin
          state_nxt = ST_ONE;
          ld_main   = 1'b1;
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            ld_main = 1'b1;
          end else if (in_xfer) begin
            state_nxt = ST_TWO;
            ld_skid   = 1'b1;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (out_xfer) begin
          state_nxt    = ST_ONE;
          ld_main_skid = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // main drives the outputs directly, so it only changes on a transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main)           main_q <= dec;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= dec;
    end
  end

  assign bus.in_ready    = in_rdy_q;
  assign bus.out_valid   = out_vld;
  assign bus.out_ctrl    = ALUCTRL_WIDTH'(main_q.ctrl);
  assign bus.out_op1     = main_q.op1;
  assign bus.out_op2     = main_q.op2;
  assign bus.out_ovf_chk = main_q.ovf_chk;
  assign bus.out_wr_en   = main_q.wr_en;
  assign bus.out_wr_reg  = main_q.wr_reg;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a queue-based reference model.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [76:0] exp_q[$];

  alu_issue_stage_if #(.CTRL_W(5)) bus ();

`ifdef ALU_ISSUE_FWD_EN
  logic        ex_wr_en = 1'b0;
  logic [4:0]  ex_wr_reg = 5'd0;
  logic [31:0] ex_res = 32'd0;
  alu_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .ex_wr_en(ex_wr_en),
                       .ex_wr_reg(ex_wr_reg), .ex_res(ex_res), .bus(bus.slave));
`else
  alu_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus.slave));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] eff_src(input logic [4:0] fld, input logic [31:0] raw);
`ifdef ALU_ISSUE_FWD_EN
    if (ex_wr_en && ex_wr_reg == fld && fld != 5'd0) return ex_res;
`endif
    if (fld == 5'd31) return raw;  // keeps fld referenced in both builds
    return raw;
  endfunction

  // Reference decode: {ctrl, op1, op2, ovf_chk, wr_en, wr_reg, illegal}
  function automatic logic [76:0] ref_dec(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0] ctrl, dst;
    logic [31:0] o1, o2, sx, zx;
    logic ovf, wen, ill;
    o1 = a; o2 = b; ovf = 0; wen = 0; ill = 0; ctrl = ALU_OP_OP2; dst = ins[20:16];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    if (ins[31:26] == 6'h00) begin
      dst = ins[15:11]; wen = 1;
      case (ins[5:0])
        6'h20: begin ctrl = ALU_OP_ADD; ovf = 1; end
        6'h21: ctrl = ALU_OP_ADDU;
        6'h22: begin ctrl = ALU_OP_SUB; ovf = 1; end
        6'h23: ctrl = ALU_OP_SUBU;
        6'h24: ctrl = ALU_OP_AND;
        6'h25: ctrl = ALU_OP_OR;
        6'h26: ctrl = ALU_OP_XOR;
        6'h27: ctrl = ALU_OP_NOR;
        6'h2A: ctrl = ALU_OP_SLT;
        6'h2B: ctrl = ALU_OP_SLTU;
        6'h00: begin ctrl = ALU_OP_SLL; o1 = {27'd0, ins[10:6]}; end
        6'h02: begin ctrl = ALU_OP_SRL; o1 = {27'd0, ins[10:6]}; end
        6'h03: begin ctrl = ALU_OP_SRA; o1 = {27'd0, ins[10:6]}; end
        6'h04: ctrl = ALU_OP_SLL;
        6'h06: ctrl = ALU_OP_SRL;
        6'h07: ctrl = ALU_OP_SRA;
        default: ill = 1;
      endcase
    end else begin
      case (ins[31:26])
        6'h01: if (ins[20:16] == 0) ctrl = ALU_OP_LTZ;
               else if (ins[20:16] == 1) ctrl = ALU_OP_GEZ;
               else ill = 1;
        6'h04: ctrl = ALU_OP_EQ;
        6'h05: ctrl = ALU_OP_NEQ;
        6'h06: ctrl = ALU_OP_LEZ;
        6'h07: ctrl = ALU_OP_GTZ;
        6'h08: begin ctrl = ALU_OP_ADD; o2 = sx; wen = 1; ovf = 1; end
        6'h09: begin ctrl = ALU_OP_ADDU; o2 = sx; wen = 1; end
        6'h0A: begin ctrl = ALU_OP_SLT; o2 = sx; wen = 1; end
        6'h0B: begin ctrl = ALU_OP_SLTU; o2 = sx; wen = 1; end
        6'h0C: begin ctrl = ALU_OP_AND; o2 = zx; wen = 1; end
        6'h0D: begin ctrl = ALU_OP_OR; o2 = zx; wen = 1; end
        6'h0E: begin ctrl = ALU_OP_XOR; o2 = zx; wen = 1; end
        6'h0F: begin ctrl = ALU_OP_LUI; o2 = zx; wen = 1; end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin ctrl = ALU_OP_ADDU; o2 = sx; wen = 1; end
        6'h28, 6'h29, 6'h2B: begin ctrl = ALU_OP_ADDU; o2 = sx; end
        default: ill = 1;
      endcase
    end
    if (ill) begin ctrl = ALU_OP_OP2; wen = 0; dst = 0; ovf = 0; end
    if (dst == 0) wen = 0;
    return {ctrl, o1, o2, ovf, wen, dst, ill};
  endfunction

  function automatic logic [76:0] obs();
    return {bus.out_ctrl, bus.out_op1, bus.out_op2, bus.out_ovf_chk, bus.out_wr_en,
            bus.out_wr_reg, bus.out_illegal};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] fn_l[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] op_l[20] = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                             6'h29, 6'h2B};
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 5))
      0, 1: begin w[31:26] = 6'h00; w[5:0] = fn_l[$urandom_range(0, 15)]; end
      2:    begin w[31:26] = 6'h01; w[20:16] = 5'($urandom_range(0, 2)); end
      3, 4: w[31:26] = op_l[$urandom_range(0, 19)];
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) begin
      w[25:21] = 5'($urandom_range(0, 7));
      if (w[31:26] != 6'h01) w[20:16] = 5'($urandom_range(0, 7));
      w[15:11] = 5'($urandom_range(0, 3));
    end
    return w;
  endfunction

  // Model update at the clock edge, using what the stage is supposed to be able to accept
  task automatic model_edge();
    bit in_x, out_x;
    in_x  = bus.in_valid && (exp_q.size() < 2);
    out_x = bus.out_ready && (exp_q.size() > 0);
    if (rst || flush) exp_q.delete();
    else begin
      if (out_x) void'(exp_q.pop_front());
      if (in_x) exp_q.push_back(ref_dec(bus.in_instr,
                                        eff_src(bus.in_instr[25:21], bus.rs_data),
                                        eff_src(bus.in_instr[20:16], bus.rt_data)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    chk("in_ready", bus.in_ready, exp_q.size() < 2);
    if (exp_q.size() != 0) chk("out_data", obs(), exp_q[0]);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.rs_data = a; bus.rt_data = b;
  endtask

  task automatic issue1(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    drive(ins, a, b);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_instr = 0; bus.rs_data = 0; bus.rt_data = 0; bus.out_ready = 0;
    rst = 1;
    step(); step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_fields", obs(), 0);
    rst = 0;

    issue1(32'h2128FFFF, 32'd5, $urandom());
    chk("addi_ctrl", bus.out_ctrl, ALU_OP_ADD);
    chk("addi_op1", bus.out_op1, 32'd5);
    chk("addi_op2", bus.out_op2, 32'hFFFFFFFF);
    chk("addi_wr", {bus.out_wr_en, bus.out_wr_reg, bus.out_ovf_chk}, {1'b1, 5'd8, 1'b1});

    issue1(32'h00084080, $urandom(), 32'd1);
    chk("sll_ctrl", bus.out_ctrl, ALU_OP_SLL);
    chk("sll_ops", {bus.out_op1, bus.out_op2}, {32'd2, 32'd1});
    chk("sll_wr_reg", bus.out_wr_reg, 5'd8);

    issue1(32'h34088000, $urandom(), $urandom());
    chk("ori_op2", bus.out_op2, 32'h00008000);
    issue1(32'h3C081234, $urandom(), $urandom());
    chk("lui_ctrl_op2", {bus.out_ctrl, bus.out_op2}, {ALU_OP_LUI, 32'h00001234});

    issue1(32'hFC000000, $urandom(), $urandom());
    chk("ill_flags", {bus.out_illegal, bus.out_wr_en}, 2'b10);

`ifdef ALU_ISSUE_FWD_EN
    ex_wr_en = 1; ex_wr_reg = 5'd9; ex_res = 32'd7;
    issue1(32'h2128FFFF, 32'd5, 32'd0);
    chk("fwd_op1", bus.out_op1, 32'd7);
    ex_wr_en = 0;
`endif

    // back-pressure: three back-to-back, only two fit
    bus.out_ready = 1; step();
    bus.out_ready = 0;
    drive(32'h01095020, 32'h11, 32'h22); step();
    chk("bp_ready_1", bus.in_ready, 1);
    drive(32'h01095022, 32'h33, 32'h44); step();
    chk("bp_ready_2", bus.in_ready, 0);
    drive(32'h01095024, 32'h55, 32'h66); step();
    bus.in_valid = 0; bus.out_ready = 1;
    step();
    chk("bp_second", bus.out_op1, 32'h33);
    step();
    chk("bp_third_dropped", bus.out_valid, 0);

    // flush while full with an input presented
    bus.out_ready = 0;
    drive(32'h21280001, 1, 2); step();
    drive(32'h21280002, 3, 4); step();
    flush = 1; drive(32'h21280003, 5, 6); step();
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_in_ready", bus.in_ready, 1);
    flush = 0; bus.in_valid = 0; step();
    chk("flush_dropped", bus.out_valid, 0);

    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 31) == 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rnd_instr();
      bus.rs_data   = $urandom();
      bus.rt_data   = $urandom();
      bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_ISSUE_FWD_EN
      ex_wr_en  = $urandom_range(0, 1) == 1;
      ex_wr_reg = 5'($urandom_range(0, 7));
      ex_res    = $urandom();
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
